// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_DATA_WIDTH      = 32;
  localparam int unsigned DMEM_STRB_WIDTH      = DMEM_DATA_WIDTH / 8;
  localparam int unsigned DMEM_DEFAULT_LATENCY = 2;
  localparam int unsigned DMEM_DEFAULT_OUTST   = 4;

  typedef struct packed {
    logic [DMEM_DATA_WIDTH-1:0] rdata;
    logic                       err;
    logic                       write;
  } dmem_resp_t;

  // Byte-lane merge of a store into an existing word.
  function automatic logic [DMEM_DATA_WIDTH-1:0] dmem_merge(
    input logic [DMEM_DATA_WIDTH-1:0] old_word,
    input logic [DMEM_DATA_WIDTH-1:0] new_word,
    input logic [DMEM_STRB_WIDTH-1:0] strb
  );
    logic [DMEM_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < int'(DMEM_STRB_WIDTH); b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_resp_fifo.sv
// First-word fall-through response FIFO; head is valid whenever empty is low.
module dmem_resp_fifo
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH = DMEM_DEFAULT_OUTST,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  dmem_resp_t       push_data,
  input  logic             pop,
  output dmem_resp_t       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dmem_resp_t       slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot being written, so push-at-full is fine alongside it.
  assign do_push = push & (~full | do_pop);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with credit-based flow control.
// Optional store acknowledgements are enabled by defining DMEM_RESP_WRITE_ACK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned LATENCY    = DMEM_DEFAULT_LATENCY,
  parameter int unsigned MAX_OUTST  = DMEM_DEFAULT_OUTST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
`ifdef DMEM_RESP_WRITE_ACK_EN
  ,
  output logic                    resp_write
`endif
);

  localparam int unsigned IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic                  rst_q;
  logic [CNT_W-1:0]      credits;
  logic                  accept;
  logic                  takes_credit;
  logic                  ret_credit;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  dmem_resp_t            new_entry;
  logic [LATENCY-1:0]    stage_vld;
  dmem_resp_t            stage_dat [LATENCY];
  dmem_resp_t            head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  unused_fifo;

  assign req_ready  = ~rst_q & (credits != '0);
  assign accept     = req_valid & req_ready & ~rst;
  assign in_range   = (req_addr < ADDR_WIDTH'(MEM_SIZE));
  assign idx        = req_addr[IDX_W-1:0];
  assign ret_credit = resp_valid & resp_ready;

`ifdef DMEM_RESP_WRITE_ACK_EN
  assign takes_credit = 1'b1;
`else
  assign takes_credit = ~req_write;
`endif

  // Response payload captured at accept; the array is read in the accept cycle.
  always_comb begin
    new_entry       = '0;
    new_entry.write = req_write;
    new_entry.err   = ~in_range;
    new_entry.rdata = (req_write | ~in_range) ? '0 : mem[idx];
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  always_ff @(posedge clk) begin
    if (accept & req_write & in_range) begin
      mem[idx] <= dmem_merge(mem[idx], req_wdata, req_wstrb);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CNT_W'(MAX_OUTST);
    end else begin
      case ({accept & takes_credit, ret_credit})
        2'b10:   credits <= credits - CNT_W'(1);
        2'b01:   credits <= credits + CNT_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Non-stalling delay line; credits keep its output from ever meeting a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_vld <= '0;
      for (int i = 0; i < int'(LATENCY); i++) stage_dat[i] <= '0;
    end else begin
      stage_vld[0] <= accept & takes_credit;
      stage_dat[0] <= new_entry;
      for (int i = 1; i < int'(LATENCY); i++) begin
        stage_vld[i] <= stage_vld[i-1];
        stage_dat[i] <= stage_dat[i-1];
      end
    end
  end

  dmem_resp_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (stage_vld[LATENCY-1]),
    .push_data (stage_dat[LATENCY-1]),
    .pop       (resp_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign resp_valid = ~fifo_empty;
  assign resp_rdata = fifo_empty ? '0 : head.rdata;
  assign resp_err   = ~fifo_empty & head.err;

`ifdef DMEM_RESP_WRITE_ACK_EN
  assign resp_write  = ~fifo_empty & head.write;
  assign unused_fifo = ^{fifo_full, fifo_count};
`else
  assign unused_fifo = ^{fifo_full, fifo_count, head.write};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (default LATENCY=2, MAX_OUTST=4, MEM_SIZE=1024).
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
`ifdef DMEM_RESP_WRITE_ACK_EN
  logic        resp_write;
`endif

  int vectors = 0;
  int errors  = 0;

  dmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
`ifdef DMEM_RESP_WRITE_ACK_EN
    ,
    .resp_write (resp_write)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one request for one cycle; acc reports whether it was accepted.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic acc);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    req_wstrb = strb;
    acc       = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic acc;
    int   idx;
    int   rx;
    int   nacc;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; resp_ready = 1'b1;

    // 1: reset
    @(negedge clk);
    chk("rst_ready_c1", req_ready, 0);
    chk("rst_valid_c1", resp_valid, 0);
    @(negedge clk);
    chk("rst_ready_c2", req_ready, 0);
    chk("rst_valid_c2", resp_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_valid", resp_valid, 0);
    chk("post_rst_rdata", resp_rdata, 0);
    chk("post_rst_err", resp_err, 0);

    // 2: store then load, exact latency
    issue(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, acc);
    chk("s2_store_acc", acc, 1);
    issue(1'b0, 32'd5, 32'h0, 4'h0, acc);
    chk("s2_load_acc", acc, 1);
    chk("s2_valid_t1", resp_valid, 0);
    @(negedge clk);
`ifdef DMEM_RESP_WRITE_ACK_EN
    chk("s2_ack_valid", resp_valid, 1);
    chk("s2_ack_write", resp_write, 1);
    chk("s2_ack_rdata", resp_rdata, 0);
`else
    chk("s2_valid_t2", resp_valid, 0);
`endif
    @(negedge clk);
    chk("s2_valid_t3", resp_valid, 1);
    chk("s2_rdata", resp_rdata, 32'hDEADBEEF);
    chk("s2_err", resp_err, 0);
`ifdef DMEM_RESP_WRITE_ACK_EN
    chk("s2_load_write", resp_write, 0);
`endif
    @(negedge clk);
    chk("s2_valid_t4", resp_valid, 0);

    // 3: partial byte-strobe store
    issue(1'b1, 32'd7, 32'h11223344, 4'hF, acc);
    issue(1'b1, 32'd7, 32'hAABBCCDD, 4'b0101, acc);
    issue(1'b0, 32'd7, 32'h0, 4'h0, acc);
    idle(2);
    chk("s3_valid", resp_valid, 1);
    chk("s3_rdata", resp_rdata, 32'h11BB33DD);
    @(negedge clk);

    // preload addresses 0..9 with known words
    for (int i = 0; i < 10; i++) begin
      issue(1'b1, 32'(i), 32'hA0000000 + 32'(i), 4'hF, acc);
      chk("preload_acc", acc, 1);
    end
    idle(4);
    chk("preload_drained", resp_valid, 0);

    // 4: backpressure, credit exhaustion, in-order drain
    resp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'(idx);
      acc = req_ready;
      @(negedge clk);
      if (acc) idx++;
    end
    req_valid = 1'b0;
    chk("s4_accepted", 32'(idx), 4);
    chk("s4_ready_low", req_ready, 0);
    chk("s4_head_valid", resp_valid, 1);
    chk("s4_head_held", resp_rdata, 32'hA0000000);
    resp_ready = 1'b1;
    rx = 0;
    for (int c = 0; c < 40 && rx < 10; c++) begin
      if (resp_valid) begin
        chk("s4_order", resp_rdata, 32'hA0000000 + 32'(rx));
        rx++;
      end
      if (idx < 10) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'(idx);
      end else begin
        req_valid = 1'b0;
      end
      acc = req_valid & req_ready;
      @(negedge clk);
      if (acc) idx++;
    end
    req_valid = 1'b0;
    chk("s4_all_issued", 32'(idx), 10);
    chk("s4_all_resp", 32'(rx), 10);

    // 5: out-of-range load and store
    issue(1'b0, 32'd1024, 32'h0, 4'h0, acc);
    idle(2);
    chk("s5_oor_valid", resp_valid, 1);
    chk("s5_oor_err", resp_err, 1);
    chk("s5_oor_rdata", resp_rdata, 0);
    @(negedge clk);
    issue(1'b1, 32'd1024, 32'hFFFFFFFF, 4'hF, acc);
    issue(1'b0, 32'd0, 32'h0, 4'h0, acc);
    @(negedge clk);
`ifdef DMEM_RESP_WRITE_ACK_EN
    chk("s5_ack_err", resp_err, 1);
    chk("s5_ack_write", resp_write, 1);
`endif
    @(negedge clk);
    chk("s5_addr0_valid", resp_valid, 1);
    chk("s5_addr0_rdata", resp_rdata, 32'hA0000000);
    chk("s5_addr0_err", resp_err, 0);
    @(negedge clk);

    // 6: reset with loads in flight
    issue(1'b1, 32'd3, 32'h33333333, 4'hF, acc);
    idle(4);
    issue(1'b0, 32'd0, 32'h0, 4'h0, acc);
    issue(1'b0, 32'd1, 32'h0, 4'h0, acc);
    rst = 1'b1;
    @(negedge clk);
    chk("s6_rst_ready", req_ready, 0);
    chk("s6_rst_valid", resp_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("s6_ready_after", req_ready, 1);
    for (int c = 0; c < 5; c++) begin
      chk("s6_no_resp", resp_valid, 0);
      @(negedge clk);
    end
    resp_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd3;
      acc = req_ready;
      @(negedge clk);
      if (acc) nacc++;
    end
    req_valid = 1'b0;
    chk("s6_credits", 32'(nacc), 4);
    resp_ready = 1'b1;
    rx = 0;
    for (int c = 0; c < 10; c++) begin
      if (resp_valid) begin
        chk("s6_addr3", resp_rdata, 32'h33333333);
        rx++;
      end
      @(negedge clk);
    end
    chk("s6_resp_count", 32'(rx), 4);
    chk("s6_idle", resp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
